reg_file: RTL and testbench
===========================

# reg_file

32-entry × 32-bit integer register file for the RV32I datapath, between decode and execute. Two combinational read ports feed the ALU operands (rs1, rs2); one synchronous write port takes the writeback result. Register x0 is hardwired to zero per the RISC-V ISA.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each register and data port
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH (32)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clk
- RegWrite  input  1  write enable for the write port
- Rs1  input  ADDR_WIDTH  read port 1 address
- Rs2  input  ADDR_WIDTH  read port 2 address
- Rd  input  ADDR_WIDTH  write address
- Write_data  input  DATA_WIDTH  write data
- read_data1  output  DATA_WIDTH  contents of register Rs1
- read_data2  output  DATA_WIDTH  contents of register Rs2

## Operation
- Storage: 32 registers x0..x31, DATA_WIDTH bits each.
- Reset: rising edge of clk with reset==0 clears all 32 registers to 0; any write requested in that cycle is discarded.
- Write: rising edge with reset==1, RegWrite==1, Rd!=0 → register[Rd] <= Write_data. RegWrite==0 → no state change.
- x0: writes to Rd==0 ignored; register 0 always reads 0.
- Read: read_data1 = register[Rs1], read_data2 = register[Rs2]; purely combinational from the address and current register state. Rs1==0 / Rs2==0 → 0.
- Both ports may address the same register; both return identical data.
- No X propagation: after first reset every output is a defined value.

## Timing
- Read latency: 0 cycles (combinational, same-cycle address-to-data).
- Write latency: value visible on read ports after the rising edge that commits it (1 cycle) in the base build.
- Output reset value: all registers 0, so read_data1/read_data2 = 0 for any address after reset edge until a new write commits.
- Reset mid-operation: reset dominates RegWrite on the same edge.
- Read-during-write, same address, same cycle: base build returns old value until the edge; see Configuration.

## Configuration
- REG_FILE_BYPASS_EN defined: write-to-read forwarding. When RegWrite==1, reset==1, Rd!=0 and Rs1==Rd (resp. Rs2==Rd), read_data1 (resp. read_data2) combinationally returns Write_data in the same cycle. Forwarding never applies for Rd==0 or while reset==0.
- Undefined: no forwarding; reads return stored contents only (new value visible after the edge).

## Structure
- Shared package (riscv_pkg): DATA_WIDTH/XLEN = 32, REG_ADDR_WIDTH = 5, NUM_REGS = 32, REG_ZERO = 5'd0.
- One sub-module natural: reg_file_read_port (address decode, x0 zero-forcing, optional bypass mux), instantiated twice for Rs1/Rs2.
- Storage array and write logic live in the top module.

## Test plan
- Reset held low 1 cycle, then release; read Rs1=3, Rs2=31 → both 0.
- Write x3=ABCD_EF01, x5=1234_5678 (one cycle each, RegWrite then deasserted); Rs1=3, Rs2=5 → read_data1=ABCD_EF01, read_data2=1234_5678.
- Write x8=DEAD_BEEF; Rs1=8, Rs2=5 → DEAD_BEEF, 1234_5678 (x5 undisturbed).
- Assert reset low 1 cycle with RegWrite=1, Rd=9, Write_data=FFFF_FFFF; then Rs1=3, Rs2=5 → 0, 0; Rs1=9 → 0.
- Write Rd=0, Write_data=CAFE_BABE; Rs1=0, Rs2=0 → 0, 0. RegWrite=0, Rd=4, Write_data=1111_1111 → x4 stays 0.
- Same-cycle Rd=Rs1=Rs2=7, Write_data=5A5A_5A5A, RegWrite=1, x7 previously 0: before edge read_data1/2 = 5A5A_5A5A with REG_FILE_BYPASS_EN, 0 without; after edge both 5A5A_5A5A in both builds.

Source files
------------

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared RV32I datapath constants used by the register file and its read
// ports.
//
// Contents:
//   XLEN / DATA_WIDTH - integer register width (32)
//   REG_ADDR_WIDTH    - register index width (5)
//   NUM_REGS          - number of architectural integer registers (32)
//   REG_ZERO          - index of the hardwired-zero register x0
//   is_reg_zero()     - helper that tests an index against x0
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN           = 32;
    localparam int DATA_WIDTH     = XLEN;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int NUM_REGS       = 2 ** REG_ADDR_WIDTH;

    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = 5'd0;

    // x0 test on a full-width register index; every other index is a
    // normal writable register.
    function automatic logic is_reg_zero(input logic [REG_ADDR_WIDTH-1:0] idx);
        return (idx == REG_ZERO);
    endfunction

endpackage : riscv_pkg

// File: rtl/reg_file_read_port.sv
// ---------------------------------------------------------------------------
// reg_file_read_port
// One combinational read port of the integer register file. Selects a
// register from the storage array, forces x0 to read as zero and, when
// built with REG_FILE_BYPASS_EN, forwards the in-flight write data to the
// port in the same cycle the write is requested.
//
// Configuration macro: REG_FILE_BYPASS_EN (write-to-read forwarding)
//
// Ports:
//   reset    - active-low reset level; forwarding is suppressed while low
//   regs     - current register contents (DEPTH x DATA_WIDTH)
//   addr     - read address
//   wr_en    - write enable of the write port
//   wr_addr  - write address of the write port
//   wr_data  - write data of the write port
//   rd_data  - data returned for addr
// ---------------------------------------------------------------------------
module reg_file_read_port
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = riscv_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] regs [DEPTH],
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

`ifdef REG_FILE_BYPASS_EN
    // A pending write to the same register wins over the stored value, so the
    // consumer sees the result without waiting for the edge. x0 and reset are
    // excluded because neither will actually commit the write.
    logic bypass_hit;
    assign bypass_hit = reset && wr_en && (wr_addr != ZERO_IDX) && (wr_addr == addr);
`else
    logic bypass_hit;
    logic unused_bypass_inputs;
    assign bypass_hit           = 1'b0;
    assign unused_bypass_inputs = &{1'b0, reset, wr_en, wr_addr, wr_data};
`endif

    // x0 is checked last so it reads zero regardless of storage or bypass.
    always_comb begin
        rd_data = regs[addr];
        if (bypass_hit) begin
            rd_data = wr_data;
        end
        if (addr == ZERO_IDX) begin
            rd_data = '0;
        end
    end

endmodule : reg_file_read_port

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
// 32 x 32-bit RV32I integer register file sitting between decode and
// execute. Two combinational read ports (rs1/rs2) feed the ALU operands and
// one synchronous write port takes the writeback result. x0 is hardwired to
// zero.
//
// Configuration macro: REG_FILE_BYPASS_EN - when defined, a write requested
// this cycle is forwarded to any read port addressing the same register.
//
// Ports:
//   clk        - system clock, state updates on the rising edge
//   reset      - synchronous active-low reset, clears every register
//   RegWrite   - write enable
//   Rs1, Rs2   - read addresses
//   Rd         - write address
//   Write_data - write data
//   read_data1 - contents of Rs1
//   read_data2 - contents of Rs2
// ---------------------------------------------------------------------------
module reg_file
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = riscv_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] Rs1,
    input  logic [ADDR_WIDTH-1:0] Rs2,
    input  logic [ADDR_WIDTH-1:0] Rd,
    input  logic [DATA_WIDTH-1:0] Write_data,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    localparam int                    DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0] regs [DEPTH];

    // Reset dominates any write on the same edge. Writes to x0 are dropped
    // here, so entry 0 only ever holds the zero loaded at reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (RegWrite && (Rd != ZERO_IDX)) begin
            regs[Rd] <= Write_data;
        end
    end

    reg_file_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_read_port1 (
        .reset   (reset),
        .regs    (regs),
        .addr    (Rs1),
        .wr_en   (RegWrite),
        .wr_addr (Rd),
        .wr_data (Write_data),
        .rd_data (read_data1)
    );

    reg_file_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_read_port2 (
        .reset   (reset),
        .regs    (regs),
        .addr    (Rs2),
        .wr_en   (RegWrite),
        .wr_addr (Rd),
        .wr_data (Write_data),
        .rd_data (read_data2)
    );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file
// Self-checking bench for reg_file: a directed vector table covering reset,
// basic writes, x0 handling, write-disable and the same-cycle read/write
// case, followed by random traffic compared against a simple array model.
// Expectations follow REG_FILE_BYPASS_EN when that macro is defined.
// ---------------------------------------------------------------------------
module tb_reg_file;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  Rs1;
    logic [4:0]  Rs2;
    logic [4:0]  Rd;
    logic [31:0] Write_data;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    int checks;
    int errors;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    reg_file dut (
        .clk        (clk),
        .reset      (reset),
        .RegWrite   (RegWrite),
        .Rs1        (Rs1),
        .Rs2        (Rs2),
        .Rd         (Rd),
        .Write_data (Write_data),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One directed cycle: inputs held for a whole cycle, outputs checked just
    // before the rising edge that may commit the write.
    typedef struct packed {
        logic        rst_n;
        logic        we;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    localparam int NUM_VECS = 15;
    vec_t vecs [NUM_VECS];

    logic [31:0] model [32];

    function automatic vec_t mk(input logic rst_n, input logic we,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [31:0] wdata,
                                input logic [31:0] exp1, input logic [31:0] exp2);
        vec_t v;
        v.rst_n = rst_n; v.we = we; v.rs1 = rs1; v.rs2 = rs2;
        v.rd = rd; v.wdata = wdata; v.exp1 = exp1; v.exp2 = exp2;
        return v;
    endfunction

    task automatic applyStimulus(input logic rst_n, input logic we,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic [31:0] wdata);
        reset      = rst_n;
        RegWrite   = we;
        Rs1        = rs1;
        Rs2        = rs2;
        Rd         = rd;
        Write_data = wdata;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Expected read value from the behavioural model for the current inputs.
    function automatic logic [31:0] expectRead(input logic [4:0] addr);
        if (addr == 5'd0) return 32'h0;
        if (BYPASS && reset && RegWrite && Rd != 5'd0 && Rd == addr) return Write_data;
        return model[addr];
    endfunction

    initial begin
        logic [31:0] byp_val;
        checks = 0;
        errors = 0;
        byp_val = BYPASS ? 32'h5A5A_5A5A : 32'h0;

        vecs[0]  = mk(1'b1, 1'b0, 5'd3,  5'd31, 5'd0, 32'h0,         32'h0,         32'h0);
        vecs[1]  = mk(1'b1, 1'b1, 5'd0,  5'd0,  5'd3, 32'hABCD_EF01, 32'h0,         32'h0);
        vecs[2]  = mk(1'b1, 1'b1, 5'd3,  5'd0,  5'd5, 32'h1234_5678, 32'hABCD_EF01, 32'h0);
        vecs[3]  = mk(1'b1, 1'b0, 5'd3,  5'd5,  5'd0, 32'h0,         32'hABCD_EF01, 32'h1234_5678);
        vecs[4]  = mk(1'b1, 1'b1, 5'd3,  5'd5,  5'd8, 32'hDEAD_BEEF, 32'hABCD_EF01, 32'h1234_5678);
        vecs[5]  = mk(1'b1, 1'b0, 5'd8,  5'd5,  5'd0, 32'h0,         32'hDEAD_BEEF, 32'h1234_5678);
        vecs[6]  = mk(1'b0, 1'b1, 5'd9,  5'd8,  5'd9, 32'hFFFF_FFFF, 32'h0,         32'hDEAD_BEEF);
        vecs[7]  = mk(1'b1, 1'b0, 5'd3,  5'd5,  5'd0, 32'h0,         32'h0,         32'h0);
        vecs[8]  = mk(1'b1, 1'b0, 5'd9,  5'd8,  5'd0, 32'h0,         32'h0,         32'h0);
        vecs[9]  = mk(1'b1, 1'b1, 5'd0,  5'd0,  5'd0, 32'hCAFE_BABE, 32'h0,         32'h0);
        vecs[10] = mk(1'b1, 1'b0, 5'd0,  5'd0,  5'd0, 32'h0,         32'h0,         32'h0);
        vecs[11] = mk(1'b1, 1'b0, 5'd4,  5'd4,  5'd4, 32'h1111_1111, 32'h0,         32'h0);
        vecs[12] = mk(1'b1, 1'b0, 5'd4,  5'd0,  5'd0, 32'h0,         32'h0,         32'h0);
        vecs[13] = mk(1'b1, 1'b1, 5'd7,  5'd7,  5'd7, 32'h5A5A_5A5A, byp_val,       byp_val);
        vecs[14] = mk(1'b1, 1'b0, 5'd7,  5'd7,  5'd0, 32'h0,         32'h5A5A_5A5A, 32'h5A5A_5A5A);

        // Initial reset: one edge with reset low.
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        @(posedge clk);

        for (int i = 0; i < NUM_VECS; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].rst_n, vecs[i].we, vecs[i].rs1, vecs[i].rs2,
                          vecs[i].rd, vecs[i].wdata);
            #1;
            checkOutput($sformatf("vec%0d read_data1", i), read_data1, vecs[i].exp1);
            checkOutput($sformatf("vec%0d read_data2", i), read_data2, vecs[i].exp2);
            @(posedge clk);
        end

        // Model matches the state left by the table.
        for (int r = 0; r < 32; r++) model[r] = 32'h0;
        model[7] = 32'h5A5A_5A5A;

        // Random traffic with occasional resets and frequent address aliasing.
        for (int n = 0; n < 400; n++) begin
            logic        r_rst;
            logic        r_we;
            logic [4:0]  r_rs1;
            logic [4:0]  r_rs2;
            logic [4:0]  r_rd;
            logic [31:0] r_wd;
            r_rst = ($urandom_range(0, 39) != 0);
            r_we  = ($urandom_range(0, 3) != 0);
            r_rd  = 5'($urandom_range(0, 31));
            r_rs1 = ($urandom_range(0, 3) == 0) ? r_rd : 5'($urandom_range(0, 31));
            r_rs2 = ($urandom_range(0, 3) == 0) ? r_rd : 5'($urandom_range(0, 31));
            r_wd  = $urandom;
            @(negedge clk);
            applyStimulus(r_rst, r_we, r_rs1, r_rs2, r_rd, r_wd);
            #1;
            checkOutput($sformatf("rand%0d read_data1", n), read_data1, expectRead(Rs1));
            checkOutput($sformatf("rand%0d read_data2", n), read_data2, expectRead(Rs2));
            @(posedge clk);
            if (!r_rst) begin
                for (int r = 0; r < 32; r++) model[r] = 32'h0;
            end else if (r_we && r_rd != 5'd0) begin
                model[r_rd] = r_wd;
            end
        end

        // Final sweep of every register through both ports.
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        for (int a = 0; a < 32; a++) begin
            Rs1 = 5'(a);
            Rs2 = 5'(31 - a);
            #1;
            checkOutput($sformatf("sweep x%0d port1", a), read_data1, expectRead(Rs1));
            checkOutput($sformatf("sweep x%0d port2", 31 - a), read_data2, expectRead(Rs2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_reg_file
